// File: rtl/branch_flow_ctrl_if.sv
// Signal bundle between the ID-stage branch controller and the pipeline.
// BRANCH_STATS_EN adds the three statistics counters to the bundle.
interface branch_flow_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [1:0]            id_branch_cmd;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  cond_taken;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  mem_mem_read;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  idex_bubble;
    logic                  ifid_flush;
    logic                  pc_sel_branch;
    logic                  busy;
`ifdef BRANCH_STATS_EN
    logic [15:0]           stat_taken;
    logic [15:0]           stat_stall;
    logic [15:0]           stat_flush;

    modport master (
        output id_branch_cmd, id_src1, id_src2, cond_taken,
        output ex_reg_write, ex_mem_read, ex_dest,
        output mem_mem_read, mem_dest,
        input  pc_write, ifid_write, idex_bubble,
        input  ifid_flush, pc_sel_branch, busy,
        input  stat_taken, stat_stall, stat_flush
    );

    modport slave (
        input  id_branch_cmd, id_src1, id_src2, cond_taken,
        input  ex_reg_write, ex_mem_read, ex_dest,
        input  mem_mem_read, mem_dest,
        output pc_write, ifid_write, idex_bubble,
        output ifid_flush, pc_sel_branch, busy,
        output stat_taken, stat_stall, stat_flush
    );
`else
    modport master (
        output id_branch_cmd, id_src1, id_src2, cond_taken,
        output ex_reg_write, ex_mem_read, ex_dest,
        output mem_mem_read, mem_dest,
        input  pc_write, ifid_write, idex_bubble,
        input  ifid_flush, pc_sel_branch, busy
    );

    modport slave (
        input  id_branch_cmd, id_src1, id_src2, cond_taken,
        input  ex_reg_write, ex_mem_read, ex_dest,
        input  mem_mem_read, mem_dest,
        output pc_write, ifid_write, idex_bubble,
        output ifid_flush, pc_sel_branch, busy
    );
`endif
endinterface

// File: rtl/branch_flow_ctrl.sv
// Branch sequencing: stalls on operand hazards, redirects and flushes on taken.
// Optional BRANCH_STATS_EN adds taken/stall/flush saturating counters.
`ifndef JUMP_CONDITION
`define JUMP_CONDITION 2'b01
`endif
`ifndef BEZ_CONDITION
`define BEZ_CONDITION 2'b10
`endif
`ifndef BNE_CONDITION
`define BNE_CONDITION 2'b11
`endif

module branch_flow_ctrl #(
    parameter int REG_ADDR_W     = 5,
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 3
) (
    input logic               clk,
    input logic               rst,
    branch_flow_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             is_br, chk1, chk2;
    logic [1:0]       need1, need2, need;
    logic             pc_write, ifid_write, idex_bubble;
    logic             ifid_flush, pc_sel_branch, busy;

    // 2 = load still in EX, 1 = result one cycle away, 0 = operand ready
    function automatic logic [1:0] src_need(
        input logic [REG_ADDR_W-1:0] s,
        input logic                  erw,
        input logic                  emr,
        input logic [REG_ADDR_W-1:0] ed,
        input logic                  mmr,
        input logic [REG_ADDR_W-1:0] md
    );
        logic [1:0] n;
        n = 2'd0;
        if (s != '0) begin
            if (erw && emr && ed == s)
                n = 2'd2;
            else if (erw && ed == s)
                n = 2'd1;
            else if (mmr && md == s)
                n = 2'd1;
        end
        return n;
    endfunction

    always_comb begin
        is_br = 1'b0;
        chk1  = 1'b0;
        chk2  = 1'b0;
        case (bus.id_branch_cmd)
            `JUMP_CONDITION: is_br = 1'b1;
            `BEZ_CONDITION: begin
                is_br = 1'b1;
                chk1  = 1'b1;
            end
            `BNE_CONDITION: begin
                is_br = 1'b1;
                chk1  = 1'b1;
                chk2  = 1'b1;
            end
            default: is_br = 1'b0;
        endcase
    end

    always_comb begin
        need1 = chk1 ? src_need(bus.id_src1, bus.ex_reg_write,
                                bus.ex_mem_read, bus.ex_dest,
                                bus.mem_mem_read, bus.mem_dest) : 2'd0;
        need2 = chk2 ? src_need(bus.id_src2, bus.ex_reg_write,
                                bus.ex_mem_read, bus.ex_dest,
                                bus.mem_mem_read, bus.mem_dest) : 2'd0;
        need  = (need1 > need2) ? need1 : need2;
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        idex_bubble   = 1'b0;
        ifid_flush    = 1'b0;
        pc_sel_branch = 1'b0;
        busy          = 1'b0;
        // Held in reset the pipeline just runs; nothing pending survives.
        if (!rst) begin
            busy = (state != RUN);
            unique case (state)
                RUN: begin
                    if (is_br && need != 2'd0) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (need == 2'd2) begin
                            cnt_n   = CNT_W'(1);
                            state_n = STALL;
                        end
                    end else if (is_br && bus.cond_taken) begin
                        pc_sel_branch = 1'b1;
                        ifid_flush    = 1'b1;
                        if (BRANCH_PENALTY > 1) begin
                            cnt_n   = CNT_W'(BRANCH_PENALTY - 1);
                            state_n = FLUSH;
                        end
                    end
                end
                STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_n       = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1))
                        state_n = RUN;
                end
                FLUSH: begin
                    ifid_flush = 1'b1;
                    cnt_n      = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1))
                        state_n = RUN;
                end
                default: begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.ifid_write    = ifid_write;
    assign bus.idex_bubble   = idex_bubble;
    assign bus.ifid_flush    = ifid_flush;
    assign bus.pc_sel_branch = pc_sel_branch;
    assign bus.busy          = busy;

`ifdef BRANCH_STATS_EN
    logic [15:0] st_taken, st_stall, st_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_taken <= '0;
            st_stall <= '0;
            st_flush <= '0;
        end else begin
            if (pc_sel_branch && st_taken != 16'hFFFF)
                st_taken <= st_taken + 16'd1;
            if (!pc_write && st_stall != 16'hFFFF)
                st_stall <= st_stall + 16'd1;
            if (ifid_flush && st_flush != 16'hFFFF)
                st_flush <= st_flush + 16'd1;
        end
    end

    assign bus.stat_taken = st_taken;
    assign bus.stat_stall = st_stall;
    assign bus.stat_flush = st_flush;
`endif
endmodule

// File: tb/tb_branch_flow_ctrl.sv
// Bench for branch_flow_ctrl: two instances (penalty 3 and 1) driven in lockstep.
// Expected outputs per cycle come from a hand-derived vector table.
`ifndef JUMP_CONDITION
`define JUMP_CONDITION 2'b01
`endif
`ifndef BEZ_CONDITION
`define BEZ_CONDITION 2'b10
`endif
`ifndef BNE_CONDITION
`define BNE_CONDITION 2'b11
`endif

module tb_branch_flow_ctrl;
    localparam logic [1:0] NB = 2'b00;
    localparam logic [1:0] J  = `JUMP_CONDITION;
    localparam logic [1:0] Z  = `BEZ_CONDITION;
    localparam logic [1:0] N  = `BNE_CONDITION;

    // {pc_write, ifid_write, idex_bubble, ifid_flush, pc_sel_branch, busy}
    localparam logic [5:0] IDL = 6'b110000;
    localparam logic [5:0] STL = 6'b001000;
    localparam logic [5:0] STB = 6'b001001;
    localparam logic [5:0] RED = 6'b110110;
    localparam logic [5:0] FLB = 6'b110101;

    typedef struct {
        logic       rst;
        logic [1:0] cmd;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       ct;
        logic       erw;
        logic       emr;
        logic [4:0] ed;
        logic       mmr;
        logic [4:0] md;
        logic [5:0] e3;
        logic [5:0] e1;
    } vec_t;

    typedef struct {
        int         idx;
        logic [5:0] e3;
        logic [5:0] e1;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[28];
    sb_t  sbq[$];

    branch_flow_ctrl_if #(.REG_ADDR_W(5)) bf3 ();
    branch_flow_ctrl_if #(.REG_ADDR_W(5)) bf1 ();

    branch_flow_ctrl #(.REG_ADDR_W(5), .BRANCH_PENALTY(3), .CNT_W(3)) dut3 (
        .clk(clk),
        .rst(rst),
        .bus(bf3.slave)
    );

    branch_flow_ctrl #(.REG_ADDR_W(5), .BRANCH_PENALTY(1), .CNT_W(3)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bf1.slave)
    );

    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        rst               = v.rst;
        bf3.id_branch_cmd = v.cmd;
        bf3.id_src1       = v.s1;
        bf3.id_src2       = v.s2;
        bf3.cond_taken    = v.ct;
        bf3.ex_reg_write  = v.erw;
        bf3.ex_mem_read   = v.emr;
        bf3.ex_dest       = v.ed;
        bf3.mem_mem_read  = v.mmr;
        bf3.mem_dest      = v.md;
        bf1.id_branch_cmd = v.cmd;
        bf1.id_src1       = v.s1;
        bf1.id_src2       = v.s2;
        bf1.cond_taken    = v.ct;
        bf1.ex_reg_write  = v.erw;
        bf1.ex_mem_read   = v.emr;
        bf1.ex_dest       = v.ed;
        bf1.mem_mem_read  = v.mmr;
        bf1.mem_dest      = v.md;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [5:0] outs3();
        return {bf3.pc_write, bf3.ifid_write, bf3.idex_bubble,
                bf3.ifid_flush, bf3.pc_sel_branch, bf3.busy};
    endfunction

    function automatic logic [5:0] outs1();
        return {bf1.pc_write, bf1.ifid_write, bf1.idex_bubble,
                bf1.ifid_flush, bf1.pc_sel_branch, bf1.busy};
    endfunction

    initial begin
        //          rst  cmd s1 s2 ct erw emr ed mmr md   e3   e1
        vecs[0]  = '{1, NB, 0, 0, 0, 0, 0, 0, 0, 0, IDL, IDL};
        vecs[1]  = '{1, NB, 0, 0, 0, 0, 0, 0, 0, 0, IDL, IDL};
        vecs[2]  = '{0, NB, 0, 0, 0, 0, 0, 0, 0, 0, IDL, IDL};
        vecs[3]  = '{0, N,  3, 4, 1, 1, 1, 3, 0, 0, STL, STL};
        vecs[4]  = '{0, N,  3, 4, 1, 0, 0, 0, 0, 0, STB, STB};
        vecs[5]  = '{0, N,  3, 4, 1, 0, 0, 0, 0, 0, RED, RED};
        vecs[6]  = '{0, N,  3, 4, 1, 1, 1, 3, 0, 0, FLB, STL};
        vecs[7]  = '{0, NB, 0, 0, 0, 0, 0, 0, 0, 0, FLB, STB};
        vecs[8]  = '{0, NB, 0, 0, 0, 0, 0, 0, 0, 0, IDL, IDL};
        vecs[9]  = '{0, J,  5, 0, 1, 1, 1, 5, 0, 0, RED, RED};
        vecs[10] = '{0, NB, 0, 0, 0, 0, 0, 0, 0, 0, FLB, IDL};
        vecs[11] = '{1, NB, 0, 0, 0, 0, 0, 0, 0, 0, IDL, IDL};
        vecs[12] = '{0, Z,  7, 0, 0, 0, 0, 0, 1, 7, STL, STL};
        vecs[13] = '{0, Z,  7, 0, 0, 0, 0, 0, 0, 0, IDL, IDL};
        vecs[14] = '{0, Z,  0, 0, 1, 1, 0, 0, 0, 0, RED, RED};
        vecs[15] = '{0, NB, 0, 0, 0, 0, 0, 0, 0, 0, FLB, IDL};
        vecs[16] = '{0, NB, 0, 0, 0, 0, 0, 0, 0, 0, FLB, IDL};
        vecs[17] = '{0, N,  1, 9, 1, 1, 0, 9, 0, 0, STL, STL};
        vecs[18] = '{0, Z,  1, 9, 1, 1, 0, 9, 0, 0, RED, RED};
        vecs[19] = '{0, NB, 0, 0, 0, 0, 0, 0, 0, 0, FLB, IDL};
        vecs[20] = '{0, NB, 0, 0, 0, 0, 0, 0, 0, 0, FLB, IDL};
        vecs[21] = '{0, N,  6, 0, 1, 1, 1, 6, 1, 6, STL, STL};
        vecs[22] = '{1, NB, 0, 0, 0, 0, 0, 0, 0, 0, IDL, IDL};
        vecs[23] = '{0, NB, 0, 0, 0, 0, 0, 0, 0, 0, IDL, IDL};
        vecs[24] = '{0, NB, 3, 0, 1, 1, 1, 3, 0, 0, IDL, IDL};
        vecs[25] = '{0, Z,  4, 0, 0, 0, 1, 4, 0, 0, IDL, IDL};
        vecs[26] = '{0, N,  2, 8, 1, 0, 0, 0, 1, 8, STL, STL};
        vecs[27] = '{0, N,  2, 8, 0, 0, 0, 0, 0, 0, IDL, IDL};

        drive(vecs[0]);
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            sbq.push_back('{i, vecs[i].e3, vecs[i].e1});
            #2;
            if (sbq.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard row %0d: got empty want entry", i);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                check("pen3_outs", e.idx, {10'd0, outs3()}, {10'd0, e.e3});
                check("pen1_outs", e.idx, {10'd0, outs1()}, {10'd0, e.e1});
            end
        end

`ifdef BRANCH_STATS_EN
        begin
            vec_t rs;
            vec_t jt;
            vec_t id;
            vec_t hz;
            rs = '{1, NB, 0, 0, 0, 0, 0, 0, 0, 0, IDL, IDL};
            jt = '{0, J,  0, 0, 1, 0, 0, 0, 0, 0, RED, RED};
            id = '{0, NB, 0, 0, 0, 0, 0, 0, 0, 0, IDL, IDL};
            hz = '{0, N,  3, 0, 0, 1, 1, 3, 0, 0, STL, STL};
            @(negedge clk);
            drive(rs);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                drive(jt);
                for (int m = 0; m < 3; m++) begin
                    @(negedge clk);
                    drive(id);
                end
            end
            @(negedge clk);
            drive(hz);
            @(negedge clk);
            drive(hz);
            @(negedge clk);
            drive(id);
            @(negedge clk);
            #2;
            check("stat_taken3", 0, bf3.stat_taken, 16'd3);
            check("stat_stall3", 0, bf3.stat_stall, 16'd2);
            check("stat_flush3", 0, bf3.stat_flush, 16'd9);
            check("stat_taken1", 0, bf1.stat_taken, 16'd3);
            check("stat_stall1", 0, bf1.stat_stall, 16'd2);
            check("stat_flush1", 0, bf1.stat_flush, 16'd3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
